sysid_ext: RTL and testbench

SYSID_EXT -- requirements
Module: sysid_ext

---
 rtl/sysid_ext.sv | 123 ++++++++++++
 tb/tb_sysid_ext.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_ext.sv
// sysid_ext -- system ID, build timestamp, 64-bit uptime counter and scratch registers
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module sysid_ext #(
  parameter logic [31:0] ID_VALUE     = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter int          NUM_SCRATCH  = 4,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam logic [15:0] VERSION = 16'h0002;
  localparam logic [31:0] CAPS    = {VERSION, 8'(READ_LATENCY), 8'(NUM_SCRATCH)};

  logic [63:0] uptime;
  logic [31:0] snap;
  logic        freeze;
  logic [31:0] scratch [8];
  logic        wr_en;
  logic        ctrl_wr;
  logic [31:0] rd_mux;
  logic        tail_v;
  logic [31:0] tail_d;

  // A simultaneous read wins; the write is dropped.
  assign wr_en   = write & ~read;
  assign ctrl_wr = wr_en && (address == 4'd5);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      uptime <= '0;
      snap   <= '0;
      freeze <= 1'b0;
    end else begin
      if (ctrl_wr && writedata[0])
        uptime <= '0;
      else if (!freeze)
        uptime <= uptime + 64'd1;
      if (ctrl_wr)
        freeze <= writedata[1];
      if (read && (address == 4'd3))
        snap <= uptime[63:32];
    end
  end

  // Words beyond NUM_SCRATCH are never written and stay at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++)
        scratch[i] <= '0;
    end else if (wr_en && address[3]) begin
      for (int i = 0; i < 8; i++)
        if ((i < NUM_SCRATCH) && (address[2:0] == 3'(i)))
          scratch[i] <= writedata;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      4'd0:    rd_mux = ID_VALUE;
      4'd1:    rd_mux = TIMESTAMP;
      4'd2:    rd_mux = CAPS;
      4'd3:    rd_mux = uptime[31:0];
      4'd4:    rd_mux = snap;
      4'd5:    rd_mux = {30'd0, freeze, 1'b0};
      default: rd_mux = address[3] ? scratch[address[2:0]] : 32'd0;
    endcase
  end

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign tail_v = read;
      assign tail_d = rd_mux;
    end else begin : g_latn
      logic [READ_LATENCY-2:0] sv;
      logic [31:0]             sd [READ_LATENCY-1];

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          sv <= '0;
          for (int i = 0; i < READ_LATENCY - 1; i++)
            sd[i] <= '0;
        end else begin
          sv[0] <= read;
          sd[0] <= rd_mux;
          for (int i = 1; i < READ_LATENCY - 1; i++) begin
            sv[i] <= sv[i-1];
            sd[i] <= sd[i-1];
          end
        end
      end

      assign tail_v = sv[READ_LATENCY-2];
      assign tail_d = sd[READ_LATENCY-2];
    end
  endgenerate

  // readdata only moves on a valid beat so it holds between responses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= tail_v;
      if (tail_v)
        readdata <= tail_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sysid_ext.sv
// tb_sysid_ext -- scoreboard bench for sysid_ext (latency 2 main instance, latency 3 reset instance)
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_sysid_ext;

  localparam logic [31:0] ID = 32'h518B_1241;
  localparam logic [31:0] TS = 32'h518B_2E41;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata, readdata3;
  logic        readdatavalid, readdatavalid3;

  always #5 clock = ~clock;

  sysid_ext #(.ID_VALUE(ID), .TIMESTAMP(TS), .NUM_SCRATCH(4), .READ_LATENCY(2)) dut (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid));

  sysid_ext #(.ID_VALUE(ID), .TIMESTAMP(TS), .NUM_SCRATCH(4), .READ_LATENCY(3)) dut3 (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata3), .readdatavalid(readdatavalid3));

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model of the register state, advanced on the same edges as the DUT.
  logic [63:0] m_up;
  logic [31:0] m_snap;
  logic        m_frz;
  logic [31:0] m_scr [4];
  logic        m_dep = 1'b0;
  logic [63:0] dep_val = '0;
  logic [63:0] m_cur;

  assign m_cur = m_dep ? dep_val : m_up;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_up   <= '0;
      m_snap <= '0;
      m_frz  <= 1'b0;
      for (int i = 0; i < 4; i++) m_scr[i] <= '0;
    end else begin
      if (read && address == 4'd3) m_snap <= m_cur[63:32];
      if (write && !read && address == 4'd5 && writedata[0]) m_up <= '0;
      else if (!m_frz) m_up <= m_cur + 64'd1;
      else m_up <= m_cur;
      if (write && !read && address == 4'd5) m_frz <= writedata[1];
      if (write && !read && address >= 4'd8 && address <= 4'd11) m_scr[address[1:0]] <= writedata;
    end
  end

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a)
      4'd0: return ID;
      4'd1: return TS;
      4'd2: return 32'h0002_0204;
      4'd3: return m_cur[31:0];
      4'd4: return m_snap;
      4'd5: return {30'd0, m_frz, 1'b0};
      4'd8, 4'd9, 4'd10, 4'd11: return m_scr[a[1:0]];
      default: return 32'd0;
    endcase
  endfunction

  // Scoreboard: expected data plus the cycle it must appear in.
  typedef struct { logic [31:0] data; int due; } exp_t;
  typedef struct { int at; logic [31:0] data; } obs_t;
  exp_t q[$];
  exp_t e_mon;
  obs_t log3[$];

  always @(negedge clock) begin
    if (readdatavalid) begin
      if (q.size() == 0) begin
        check("unexpected_rdv", 64'(readdatavalid), 64'd0);
      end else begin
        e_mon = q.pop_front();
        check("rd_latency", 64'(cyc), 64'(e_mon.due));
        check("rd_data", 64'(readdata), 64'(e_mon.data));
      end
    end else if (q.size() != 0 && q[0].due < cyc) begin
      check("rd_missing", 64'(readdatavalid), 64'd1);
      void'(q.pop_front());
    end
    if (readdatavalid3) log3.push_back('{cyc, readdata3});
  end

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    @(negedge clock);
    address = a; read = 1'b1; write = 1'b0;
    q.push_back('{e, cyc + 2});
  endtask

  task automatic rdm(input logic [3:0] a);
    @(negedge clock);
    address = a; read = 1'b1; write = 1'b0;
    q.push_back('{m_read(a), cyc + 2});
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clock);
    address = a; read = 1'b0; write = 1'b1; writedata = d;
  endtask

  task automatic rdwr(input logic [3:0] a, input logic [31:0] d, input logic [31:0] e);
    @(negedge clock);
    address = a; read = 1'b1; write = 1'b1; writedata = d;
    q.push_back('{e, cyc + 2});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      read = 1'b0; write = 1'b0;
    end
  endtask

  typedef struct { bit is_wr; logic [3:0] addr; logic [31:0] data; } vec_t;
  vec_t vt [16];
  int   t0;

  initial begin
    vt[0]  = '{1'b0, 4'd0,  ID};
    vt[1]  = '{1'b0, 4'd1,  TS};
    vt[2]  = '{1'b0, 4'd2,  32'h0002_0204};
    vt[3]  = '{1'b1, 4'd9,  32'hDEAD_BEEF};
    vt[4]  = '{1'b0, 4'd9,  32'hDEAD_BEEF};
    vt[5]  = '{1'b0, 4'd12, 32'h0000_0000};
    vt[6]  = '{1'b0, 4'd6,  32'h0000_0000};
    vt[7]  = '{1'b0, 4'd7,  32'h0000_0000};
    vt[8]  = '{1'b1, 4'd0,  32'h1234_5678};
    vt[9]  = '{1'b0, 4'd0,  ID};
    vt[10] = '{1'b1, 4'd2,  32'hFFFF_FFFF};
    vt[11] = '{1'b0, 4'd2,  32'h0002_0204};
    vt[12] = '{1'b1, 4'd13, 32'hCAFE_0013};
    vt[13] = '{1'b0, 4'd13, 32'h0000_0000};
    vt[14] = '{1'b0, 4'd10, 32'h0000_0000};
    vt[15] = '{1'b0, 4'd5,  32'h0000_0000};

    repeat (3) @(negedge clock);
    check("reset_readdata", 64'(readdata), 64'd0);
    check("reset_rdv", 64'(readdatavalid), 64'd0);
    check("reset_readdata3", 64'(readdata3), 64'd0);
    check("reset_rdv3", 64'(readdatavalid3), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      if (vt[i].is_wr) wr(vt[i].addr, vt[i].data);
      else rd(vt[i].addr, vt[i].data);
    end
    idle(3);

    // A later write must not disturb a response already in flight.
    rd(4'd9, 32'hDEAD_BEEF);
    wr(4'd9, 32'h0BAD_F00D);
    rd(4'd9, 32'h0BAD_F00D);
    idle(2);

    // Same-cycle read and write: read wins, write is lost.
    wr(4'd8, 32'h5555_AAAA);
    rdwr(4'd8, 32'h0000_1234, 32'h5555_AAAA);
    rd(4'd8, 32'h5555_AAAA);
    idle(2);

    // Snapshot of the high word taken with the low-word read.
    @(negedge clock);
    dut.uptime = 64'h0000_0001_FFFF_FFFF;
    dep_val = 64'h0000_0001_FFFF_FFFF;
    m_dep = 1'b1;
    address = 4'd3; read = 1'b1; write = 1'b0;
    q.push_back('{32'hFFFF_FFFF, cyc + 2});
    @(negedge clock);
    m_dep = 1'b0;
    read = 1'b0;
    idle(3);
    rd(4'd4, 32'h0000_0001);
    rdm(4'd3);
    rd(4'd4, 32'h0000_0002);
    idle(2);

    // Freeze, then clear while frozen.
    wr(4'd5, 32'h0000_0002);
    idle(10);
    rdm(4'd3);
    rdm(4'd3);
    rd(4'd5, 32'h0000_0002);
    wr(4'd5, 32'h0000_0003);
    idle(1);
    rd(4'd3, 32'h0000_0000);
    idle(3);
    rd(4'd3, 32'h0000_0000);
    rd(4'd5, 32'h0000_0002);
    wr(4'd5, 32'h0000_0000);
    idle(2);
    rdm(4'd3);
    rdm(4'd3);
    idle(4);

    // Reset one cycle after a read: the read must vanish on both instances.
    log3.delete();
    @(negedge clock);
    address = 4'd0; read = 1'b1; write = 1'b0;
    @(negedge clock);
    read = 1'b0; reset = 1'b1;
    q.delete();
    @(negedge clock);
    check("rst_readdata", 64'(readdata), 64'd0);
    check("rst_rdv", 64'(readdatavalid), 64'd0);
    check("rst_readdata3", 64'(readdata3), 64'd0);
    check("rst_rdv3", 64'(readdatavalid3), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    address = 4'd0; read = 1'b1;
    t0 = cyc;
    q.push_back('{ID, cyc + 2});
    rd(4'd8, 32'd0);
    rd(4'd9, 32'd0);
    rd(4'd10, 32'd0);
    rd(4'd11, 32'd0);
    rd(4'd5, 32'd0);
    rd(4'd4, 32'd0);
    idle(6);
    check("lat3_count", 64'(log3.size()), 64'd7);
    if (log3.size() > 0) begin
      check("lat3_first_at", 64'(log3[0].at), 64'(t0 + 3));
      check("lat3_first_data", 64'(log3[0].data), 64'(ID));
    end

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clock);
    check("drain", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
